regfile_burst_reader: RTL
=========================

// Module: regfile_burst_reader
// PURPOSE
//  Read-side initiator for the regfile storage block. Accepts a burst request (base
//  address, length) and drives the regfile address port. Captures returned words,
//  which arrive one cycle after the address due to the regfile's registered address.
//  Streams words out through a valid/ready interface, buffered against backpressure.
//  Sits between the regfile and any consumer (ALU operand fetch, debug dump, DMA out).
// PARAMETERS
//  DW          `DATA_WIDTH        data word width, equal to the regfile data width
//  AW          `DATA_ADDR_WIDTH   regfile address width
//  FIFO_DEPTH  4                  output buffer entries (power of 2, >=4)
// PORTS
//  clk            in   1     single clock, all logic on rising edge
//  rst            in   1     asynchronous, active-high reset
//  i_start        in   1     burst request; sampled only while o_busy==0
//  i_base_addr    in   AW    first regfile address of burst
//  i_length       in   AW+1  number of words to read (0 = empty burst)
//  o_busy         out  1     burst in progress
//  o_done         out  1     one-cycle pulse: burst complete
//  o_rf_address   out  AW    registered address driven to regfile
//  o_rf_write_en  out  1     regfile write enable; constant 0 (reader only)
//  i_rf_data      in   DW    regfile read data; valid 1 cycle after o_rf_address
//  o_valid        out  1     o_data holds a valid word
//  i_ready        in   1     consumer accepts word when o_valid&&i_ready
//  o_data         out  DW    burst word, in ascending-address order
// BEHAVIOUR
//  Reset (async, rst=1): FSM=IDLE, FIFO empty, counters 0, in-flight tags cleared.
//   o_busy=0, o_done=0, o_valid=0, o_data=0, o_rf_address=0, o_rf_write_en=0.
//   Reset mid-burst: burst abandoned, in-flight read discarded, no o_done.
//  FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
//   IDLE: i_start=1 latches base/length, issue_cnt=0; ->ISSUE (length!=0).
//     length==0: -> DRAIN directly, no beats, o_done pulses the following cycle.
//   ISSUE: one address per cycle when (fifo_count + inflight) < FIFO_DEPTH;
//     inflight = issued addresses not yet captured (0..2). Address k of the burst is
//     (base+k) mod 2^AW, so wrap past 2^AW-1 returns to 0. Lengths above 2^AW
//     re-read wrapped addresses. When issue_cnt==length: ->DRAIN.
//   DRAIN: wait until inflight==0, FIFO empty, and last beat accepted. Then o_done=1
//     for exactly one cycle and o_busy=0 in that same cycle; ->IDLE.
//  o_busy=1 from the cycle after i_start is accepted up to, not including, o_done.
//  i_start while o_busy=1: ignored, no queuing.
//  Capture: a 2-stage valid tag tracks issued addresses (addr reg, regfile addr reg).
//   i_rf_data is pushed into the FIFO in the cycle its tag reaches stage 2.
//   The issue rule guarantees the FIFO never overflows, so no capture is dropped.
//  Output: o_data/o_valid come from the FIFO head, registered.
//   Push and pop may occur in the same cycle. Data and order are held stable
//   while o_valid=1 and i_ready=0.
//  Latency: i_start sampled at edge E0 -> o_rf_address=base after E0 ->
//   first o_valid after E2. With i_ready held at 1: one beat per cycle, no bubbles.
//  o_rf_address holds its last value when not issuing. o_rf_write_en is never 1.
// TESTING
//  1. Preload rf[i]=i+0x10. start base=3, len=4, ready=1 -> o_valid after E2;
//     0x13,0x14,0x15,0x16 on consecutive cycles; o_done 1 cycle after last beat.
//  2. base=2^AW-2, len=4 -> addresses 2^AW-2, 2^AW-1, 0, 1 in order; data matches.
//  3. len=8, ready toggles 1,0,0,1 repeating -> all 8 words in order, none lost or
//     duplicated; o_data stable while stalled; issue pauses when FIFO+inflight==4.
//  4. len=0 -> no o_valid; o_done pulses once; o_busy=1 for 1 cycle only.
//  5. Assert rst mid-burst (after 2 beats) -> all outputs 0 immediately, no o_done.
//     New start afterwards returns the correct full burst.
//  6. i_start pulsed while busy -> ignored: beat count equals first request only;
//     o_rf_write_en=0 throughout every test.

Source files
------------

// File: rtl/regfile_burst_reader.sv
// -----------------------------------------------------------------------------
// regfile_burst_reader
//
// Read-side initiator for the regfile storage block. A burst request (base
// address, length) is turned into one regfile address per cycle. The regfile
// registers its address, so each word appears on i_rf_data one cycle after
// its address was driven. A two-stage valid tag follows every issued address
// through that pipeline. The word is written into a small output FIFO when its
// tag reaches stage 2. Words leave through a valid/ready interface in
// ascending-address order.
//
// Ports
//   clk            in   1      single clock, rising edge
//   rst            in   1      asynchronous, active-high reset
//   i_start        in   1      burst request, sampled only while o_busy==0
//   i_base_addr    in   AW     first regfile address of the burst
//   i_length       in   AW+1   number of words (0 = empty burst)
//   o_busy         out  1      burst in progress
//   o_done         out  1      one-cycle pulse when the burst completes
//   o_rf_address   out  AW     registered regfile address
//   o_rf_write_en  out  1      regfile write enable, always 0
//   i_rf_data      in   DW     regfile read data, one cycle after address
//   o_valid        out  1      o_data holds a valid word
//   i_ready        in   1      consumer takes the word when o_valid&&i_ready
//   o_data         out  DW     burst word
// -----------------------------------------------------------------------------
module regfile_burst_reader #(
  parameter int DW         = 8,
  parameter int AW         = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_addr,
  input  logic [AW:0]   i_length,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_rf_address,
  output logic          o_rf_write_en,
  input  logic [DW-1:0] i_rf_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);

  localparam int PW = $clog2(FIFO_DEPTH);  // FIFO pointer width
  localparam int CW = PW + 1;              // FIFO count width (0..DEPTH)
  localparam int OW = PW + 2;              // count + in-flight width
  localparam int LW = AW + 1;              // length / issue counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   next_addr_q, next_addr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [AW-1:0]   rf_addr_q, rf_addr_d;
  logic            done_q, done_d;
  logic            tag1_q, tag2_q;
  logic            issue_s;

  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            push_s, pop_s;
  logic [OW-1:0]   occupancy_s;
  logic            room_s;
  logic            drained_s;

  // FIFO push/pop decisions, next count, and issue headroom.
  always_comb begin
    push_s      = tag2_q;
    pop_s       = (count_q != {CW{1'b0}}) && i_ready;
    count_d     = count_q + CW'(push_s) - CW'(pop_s);
    // Words already in the FIFO plus reads still in the regfile pipeline must
    // leave a free slot, otherwise a returning word could find the FIFO full.
    occupancy_s = OW'(count_q) + OW'(tag1_q) + OW'(tag2_q);
    room_s      = occupancy_s < OW'(FIFO_DEPTH);
    // Burst is finished when nothing is in flight and the last word leaves
    // the FIFO at this edge.
    drained_s   = !tag1_q && !tag2_q && (count_d == {CW{1'b0}});
  end

  // Burst FSM: next state, address generation and done pulse.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    rf_addr_d   = rf_addr_q;
    done_d      = 1'b0;
    issue_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          len_d = i_length;
          if (i_length != {LW{1'b0}}) begin
            // First address goes out on the accepting edge itself.
            issue_s     = 1'b1;
            rf_addr_d   = i_base_addr;
            next_addr_d = i_base_addr + AW'(1);
            issue_cnt_d = LW'(1);
            state_d     = ST_ISSUE;
          end else begin
            issue_cnt_d = {LW{1'b0}};
            state_d     = ST_DRAIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_cnt_q == len_q) begin
          state_d = ST_DRAIN;
        end else if (room_s) begin
          // Address arithmetic wraps modulo 2^AW by width truncation.
          issue_s     = 1'b1;
          rf_addr_d   = next_addr_q;
          next_addr_d = next_addr_q + AW'(1);
          issue_cnt_d = issue_cnt_q + LW'(1);
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drained_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, address and read-pipeline tag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      next_addr_q <= {AW{1'b0}};
      len_q       <= {LW{1'b0}};
      issue_cnt_q <= {LW{1'b0}};
      rf_addr_q   <= {AW{1'b0}};
      done_q      <= 1'b0;
      tag1_q      <= 1'b0;
      tag2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      rf_addr_q   <= rf_addr_d;
      done_q      <= done_d;
      // Stage 1: address register; stage 2: regfile's own address register.
      tag1_q      <= issue_s;
      tag2_q      <= tag1_q;
    end
  end

  // Output FIFO storage, pointers and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= i_rf_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_rf_address  = rf_addr_q;
  assign o_rf_write_en = 1'b0;
  assign o_valid       = (count_q != {CW{1'b0}});
  // Data is forced to zero while nothing valid is at the head.
  assign o_data        = o_valid ? mem_q[rd_ptr_q] : {DW{1'b0}};

endmodule
